// File: rtl/datapath_mc.sv
// Multi-cycle 5-state datapath: 32-entry register file, ALU, addi, halt.
// Build option DATAPATH_MC_BRANCH_EN adds beq (opcode 0x04) and j (opcode 0x02).
module datapath_mc #(
   parameter int N      = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [31:0]       instr_data,
   output logic [ADDR_W-1:0] pc,
   input  logic [4:0]        dbg_ra,
   output logic [N-1:0]      dbg_rd,
   output logic [N-1:0]      alu_out,
   output logic              zero,
   output logic [2:0]        state,
   output logic              halted
);

   // state    | meaning
   // S_FETCH  | latch instruction, advance pc
   // S_DECODE | read operands A/B from register file
   // S_EXEC   | compute ALU result, resolve branch/halt/NOP
   // S_WB     | write alu_out to destination register
   // S_HALT   | stopped until reset
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   state_t              state_q, state_d;
   logic [31:0]         ir;
   logic [N-1:0]        a_q, b_q, alu_q;
   logic [N-1:0]        regs [32];
   logic [ADDR_W-1:0]   pc_q;

   logic [5:0]          op, funct;
   logic [N-1:0]        imm_n, alu_res;
   logic                alu_valid;
   logic [4:0]          wb_dst;
   logic                branch_ld;
   logic [ADDR_W-1:0]   branch_tgt;
   logic                unused_shamt;

   assign op           = ir[31:26];
   assign funct        = ir[5:0];
   assign imm_n        = N'($signed(ir[15:0]));
   assign wb_dst       = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
   assign unused_shamt = ^ir[10:6];

   always_comb begin
      alu_valid = 1'b0;
      alu_res   = alu_q;
      case (op)
         OP_RTYPE: begin
            alu_valid = 1'b1;
            case (funct)
               6'h20:   alu_res = a_q + b_q;
               6'h22:   alu_res = a_q - b_q;
               6'h24:   alu_res = a_q & b_q;
               6'h25:   alu_res = a_q | b_q;
               6'h2A:   alu_res = ($signed(a_q) < $signed(b_q)) ? N'(1) : '0;
               default: alu_valid = 1'b0;
            endcase
         end
         OP_ADDI: begin
            alu_valid = 1'b1;
            alu_res   = a_q + imm_n;
         end
         default: alu_valid = 1'b0;
      endcase
   end

`ifdef DATAPATH_MC_BRANCH_EN
   // pc already points past the branch when the offset is applied
   always_comb begin
      branch_ld  = ((op == 6'h04) && (a_q == b_q)) || (op == 6'h02);
      branch_tgt = (op == 6'h02) ? ir[ADDR_W-1:0]
                                 : pc_q + ADDR_W'($signed(ir[15:0]));
   end
`else
   always_comb begin
      branch_ld  = 1'b0;
      branch_tgt = pc_q;
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (op == OP_HALT)  state_d = S_HALT;
            else if (alu_valid) state_d = S_WB;
            else                state_d = S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)     state_q <= S_FETCH;
      else if (en) state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir    <= '0;
         pc_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (en) begin
         case (state_q)
            S_FETCH: begin
               ir   <= instr_data;
               pc_q <= pc_q + ADDR_W'(1);
            end
            S_DECODE: begin
               a_q <= regs[ir[25:21]];
               b_q <= regs[ir[20:16]];
            end
            S_EXEC: begin
               if (alu_valid) alu_q <= alu_res;
               if (branch_ld) pc_q  <= branch_tgt;
            end
            S_WB: begin
               if (wb_dst != 5'd0) regs[wb_dst] <= alu_q;
            end
            default: ;
         endcase
      end
   end

   assign pc      = pc_q;
   assign dbg_rd  = (dbg_ra == 5'd0) ? '0 : regs[dbg_ra];
   assign alu_out = alu_q;
   assign zero    = (alu_q == '0);
   assign state   = state_q;
   assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_datapath_mc.sv
// Scoreboard bench for datapath_mc: an instruction-level model predicts each
// retirement (pc, alu_out, cycles, written register); a monitor compares them.
module tb_datapath_mc;
   localparam int N  = 8;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [31:0]   instr_data;
   logic [AW-1:0] pc;
   logic [4:0]    dbg_ra = 5'd0;
   logic [N-1:0]  dbg_rd, alu_out;
   logic          zero, halted;
   logic [2:0]    state;
   logic [31:0]   rom [256];

   assign instr_data = rom[pc];

   datapath_mc #(.N(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .en(en), .instr_data(instr_data), .pc(pc),
      .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .alu_out(alu_out), .zero(zero),
      .state(state), .halted(halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int pc; int alu; int halted; int cycles; int ridx; int rval;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic int sx16(logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic int to_signed8(int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   // Instruction-set model: run the ROM program from reset until halt.
   task automatic model_run();
      int mr[32];
      int mpc, malu, op, fn, rs, rt, rd, dst, a, b, res;
      bit wr;
      logic [31:0] ins;
      exp_t e;
      foreach (mr[i]) mr[i] = 0;
      mpc = 0; malu = 0; dst = 0; res = 0;
      for (int step = 0; step < 300; step++) begin
         ins = rom[mpc];
         mpc = (mpc + 1) % 256;
         op = ins[31:26]; fn = ins[5:0];
         rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
         a = mr[rs]; b = mr[rt];
         e = '{pc:0, alu:0, halted:0, cycles:3, ridx:rs, rval:a};
         wr = 1'b0;
         if (op == 0) begin
            wr = 1'b1; dst = rd;
            case (fn)
               'h20: res = (a + b) & 255;
               'h22: res = (a - b) & 255;
               'h24: res = a & b;
               'h25: res = a | b;
               'h2A: res = (to_signed8(a) < to_signed8(b)) ? 1 : 0;
               default: wr = 1'b0;
            endcase
         end else if (op == 'h08) begin
            wr = 1'b1; dst = rt;
            res = (a + sx16(ins[15:0])) & 255;
         end else if (op == 'h3F) begin
            e.halted = 1;
`ifdef DATAPATH_MC_BRANCH_EN
         end else if (op == 'h04) begin
            if (a == b) mpc = (mpc + sx16(ins[15:0])) & 255;
         end else if (op == 'h02) begin
            mpc = ins[7:0];
`endif
         end
         if (wr) begin
            malu = res;
            if (dst != 0) mr[dst] = res;
            e.cycles = 4; e.ridx = dst; e.rval = mr[dst];
         end
         e.pc = mpc; e.alu = malu;
         exp_q.push_back(e);
         if (e.halted != 0) break;
      end
   endtask

   bit rst_s = 1'b1;
   bit en_s  = 1'b0;
   always @(posedge clk) begin
      rst_s = rst;
      en_s  = en;
   end

   // Monitor: a retirement is any entry into FETCH or HALT not caused by reset.
   initial begin
      int cnt;
      logic [2:0] prev;
      exp_t e;
      cnt = 0; prev = 3'd0;
      forever begin
         @(negedge clk);
         if (rst_s) begin
            cnt = 0;
            prev = state;
         end else begin
            if (en_s) cnt++;
            if (state != prev && (state == 3'd0 || state == 3'd4)) begin
               chk("retire_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("ret_pc", pc, e.pc);
                  chk("ret_alu_out", alu_out, e.alu);
                  chk("ret_zero", zero, int'(e.alu == 0));
                  chk("ret_halted", halted, e.halted);
                  chk("ret_cycles", cnt, e.cycles);
                  dbg_ra = e.ridx[4:0];
                  #1;
                  chk("ret_reg", dbg_rd, e.rval);
               end
               cnt = 0;
            end
            prev = state;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) rom[i] = 32'hFC00_0000;
   endtask

   task automatic run_program(bit rand_en, int freeze_pc, bit hold_check);
      bit done;
      int snap_pc, snap_alu, snap_st, fpc;
      done = 1'b0; fpc = freeze_pc;
      rst = 1'b1; en = 1'b1;
      tick(); tick();
      chk("rst_pc", pc, 0);
      chk("rst_state", state, 0);
      chk("rst_alu_out", alu_out, 0);
      chk("rst_zero", zero, 1);
      chk("rst_halted", halted, 0);
      model_run();
      rst = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         tick();
         if (halted && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         if (fpc >= 0 && state == 3'd2 && int'(pc) == fpc) begin
            en = 1'b0;
            snap_pc = pc; snap_alu = alu_out; snap_st = state;
            repeat (5) begin
               tick();
               chk("freeze_state", state, snap_st);
               chk("freeze_pc", pc, snap_pc);
               chk("freeze_alu_out", alu_out, snap_alu);
            end
            en = 1'b1;
            tick();
            chk("resume_to_wb", state, 3);
            fpc = -1;
         end else begin
            en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
      chk("run_done", done, 1);
      if (hold_check) begin
         snap_pc = pc;
         repeat (10) begin
            tick();
            chk("halt_hold_halted", halted, 1);
            chk("halt_hold_state", state, 4);
            chk("halt_hold_pc", pc, snap_pc);
         end
      end
      chk("queue_drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      bit got_decode;
      int kind;
      int fns[6];
      int ops[3];
      fns = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h21};
      ops = '{'h23, 'h2B, 'h0D};

      // Arithmetic, wrap, r0, NOPs, slt signedness, freeze during EXEC of sub
      fill_halt();
      rom[0]  = 32'h2001_0005;
      rom[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
      rom[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h22);
      rom[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h2A);
      rom[4]  = enc_r(5'd0, 5'd0, 5'd5, 6'h20);
      rom[5]  = enc_i(6'h08, 5'd0, 5'd6, 16'h007F);
      rom[6]  = enc_i(6'h08, 5'd6, 5'd6, 16'h0001);
      rom[7]  = enc_i(6'h08, 5'd0, 5'd0, 16'h0003);
      rom[8]  = enc_r(5'd1, 5'd2, 5'd7, 6'h25);
      rom[9]  = enc_r(5'd1, 5'd2, 5'd8, 6'h24);
      rom[10] = enc_i(6'h23, 5'd1, 5'd2, 16'h0004);
      rom[11] = enc_r(5'd1, 5'd2, 5'd9, 6'h21);
      rom[12] = enc_r(5'd2, 5'd1, 5'd9, 6'h2A);
      rom[13] = enc_r(5'd3, 5'd1, 5'd10, 6'h2A);
      rom[14] = enc_i(6'h08, 5'd0, 5'd11, 16'hFFFF);
      run_program(1'b0, 3, 1'b1);

      // Branch / jump flow (NOPs when the branch option is not built)
      fill_halt();
      rom[0]    = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      rom[1]    = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
      rom[2]    = enc_i(6'h23, 5'd0, 5'd0, 16'd0);
      rom[3]    = 32'h1022_0002;
      rom[4]    = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
      rom[6]    = 32'h0800_0010;
      rom[8'h10] = enc_i(6'h08, 5'd0, 5'd10, 16'd2);
      rom[8'h11] = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
      run_program(1'b0, -1, 1'b0);

      // Reset in the middle of DECODE
      fill_halt();
      rom[0] = enc_r(5'd1, 5'd2, 5'd7, 6'h20);
      rst = 1'b1; en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      got_decode = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state == 3'd1) begin
            got_decode = 1'b1;
            break;
         end
      end
      chk("reach_decode", got_decode, 1);
      rst = 1'b1;
      tick();
      chk("midrst_pc", pc, 0);
      chk("midrst_state", state, 0);
      chk("midrst_alu_out", alu_out, 0);
      chk("midrst_halted", halted, 0);

      // Random programs, some with random enable gaps
      for (int p = 0; p < 4; p++) begin
         fill_halt();
         for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)
               rom[i] = enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              16'($urandom_range(0, 65535)));
            else if (kind < 9)
               rom[i] = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 6'(fns[$urandom_range(0, 5)]));
            else
               rom[i] = enc_i(6'(ops[$urandom_range(0, 2)]), 5'd1, 5'd2, 16'd0);
         end
         run_program(p[0], -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
